// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (data width, parity, stop bits), 2-flop input
//   synchroniser, 3-sample majority vote at bit centre, valid/ready output register.
// Latency: pin fall -> valid_o after 3 + CLOCKS_PER_BIT/2 + N*CLOCKS_PER_BIT cycles,
//   N = DATA_BITS + (PARITY!=0) + STOP_BITS.
// Backpressure: a word completing while the previous one is unaccepted is dropped and
//   overrun_o pulses for one cycle; the held word and its flags stay untouched.
// Ports: clk/resetn (async active-low); serial_i raw RX pin; data_o/parity_err_o/frame_err_o
//   qualified by valid_o, consumed on valid_o&ready_i; overrun_o pulse; busy_o = not IDLE.
module uart_rx_cfg #(
  parameter int CLOCKS_PER_BIT = 128,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 serial_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int CW = 4;
  localparam logic [TW-1:0] HALF      = TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL      = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  // Required XOR of data and parity bit: 1 for odd parity, 0 for even.
  localparam logic          PAR_EXP   = (PARITY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [2:0]             hist_q, hist_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_pend_q, perr_pend_d;
  logic                   ferr_pend_q, ferr_pend_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;

  logic line;
  logic sample;
  logic tick;
  logic done;
  logic accept;

  assign line   = sync_q[1];
  assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign tick   = (timer_q == '0);
  assign accept = valid_q & ready_i;

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], serial_i};
    hist_d      = {hist_q[1:0], line};
    timer_d     = tick ? '0 : timer_q - 1'b1;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    ovr_d       = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        // Start only on a falling edge so a held-low line (break) cannot re-trigger.
        if (!line && hist_q[0]) begin
          state_d = START;
          timer_d = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!sample) begin
            state_d     = DATA;
            timer_d     = FULL;
            cnt_d       = '0;
            perr_pend_d = 1'b0;
            ferr_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (cnt_q == CW'(i)) shreg_d[i] = sample;
          end
          timer_d = FULL;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          perr_pend_d = ((^shreg_q) ^ sample) != PAR_EXP;
          timer_d     = FULL;
          cnt_d       = '0;
          state_d     = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          timer_d = FULL;
          if (!sample) ferr_pend_d = 1'b1;
          if (cnt_q == LAST_STOP) begin
            // Back to IDLE at the stop-bit centre so the next start edge is not missed.
            done    = 1'b1;
            state_d = IDLE;
            timer_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || accept) begin
        data_d  = shreg_q;
        perr_d  = perr_pend_q;
        ferr_d  = ferr_pend_q | ~sample;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      hist_q      <= 3'b111;
      timer_q     <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule
